// File: rtl/seq_nonrestoring_divider.sv
// Iterative non-restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_nonrestoring_divider #(
    parameter  int W     = 8,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder,
    output logic         o_dbz
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         state_q;
    logic [W:0]     p_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   den_q;
    logic [W-1:0]   dvd_q;
    logic [CNT_W-1:0] cnt_q;
    logic           dbz_q;

    logic [W:0]     p_shl, den_ext, p_d;
    logic [W-1:0]   rem_fix, q_res, r_res;
    logic [W-1:0]   dvd_in, dvs_in;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_rem_q;
`endif

    // Operand magnitudes fed into the unsigned core
    always_comb begin
        dvd_in = i_dividend;
        dvs_in = i_divisor;
`ifdef DIV_SIGNED_EN
        if (i_dividend[W-1]) dvd_in = ~i_dividend + W'(1);
        if (i_divisor[W-1])  dvs_in = ~i_divisor + W'(1);
`endif
    end

    always_comb begin
        p_shl   = {p_q[W-1:0], quo_q[W-1]};
        den_ext = {1'b0, den_q};
        p_d     = p_q[W] ? (p_shl + den_ext) : (p_shl - den_ext);
        // Final remainder lies in [0,D), so W-bit modular add is exact
        rem_fix = p_q[W] ? (p_q[W-1:0] + den_q) : p_q[W-1:0];
        q_res   = quo_q;
        r_res   = rem_fix;
`ifdef DIV_SIGNED_EN
        if (neg_quo_q) q_res = ~quo_q + W'(1);
        if (neg_rem_q) r_res = ~rem_fix + W'(1);
`endif
        if (dbz_q) begin
            q_res = '1;
            r_res = dvd_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            quo_q       <= '0;
            den_q       <= '0;
            dvd_q       <= '0;
            cnt_q       <= '0;
            dbz_q       <= 1'b0;
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid && o_ready) begin
                        quo_q   <= dvd_in;
                        den_q   <= dvs_in;
                        dvd_q   <= i_dividend;
                        p_q     <= '0;
                        cnt_q   <= CNT_W'(W);
                        dbz_q   <= (i_divisor == '0);
                        o_ready <= 1'b0;
                        state_q <= S_CALC;
`ifdef DIV_SIGNED_EN
                        neg_quo_q <= i_dividend[W-1] ^ i_divisor[W-1];
                        neg_rem_q <= i_dividend[W-1];
`endif
                    end
                end
                S_CALC: begin
                    p_q   <= p_d;
                    quo_q <= {quo_q[W-2:0], ~p_d[W]};
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    o_quotient  <= q_res;
                    o_remainder <= r_res;
                    o_dbz       <= dbz_q;
                    o_valid     <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Bench for seq_nonrestoring_divider: vector table through a scoreboard plus stall/reset sequences.
module tb_seq_nonrestoring_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] dvd = '0, dvs = '0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [W-1:0] quo, rem;
    logic         dbz;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         z;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    seq_nonrestoring_divider #(.W(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_i), .o_ready(ready_o),
        .i_dividend(dvd), .i_divisor(dvs), .o_valid(valid_o), .i_ready(ready_i),
        .o_quotient(quo), .o_remainder(rem), .o_dbz(dbz)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic issue(input logic [W-1:0] a, b, q, r, input logic z, input bit push);
        vec_t v;
        int   n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("issue_ready_timeout", 64'(n < 100), 64'd1);
        dvd = a; dvs = b; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        dvd = ~a; dvs = ~b;
        v.a = a; v.b = b; v.q = q; v.r = r; v.z = z;
        if (push) sb.push_back(v);
    endtask

    // Entered just after the accept edge: checks latency, pops and compares.
    task automatic collect(input string name);
        vec_t v;
        int   n = 0;
        while (n < 40) begin
            @(negedge clk); n++;
            if (valid_o) break;
        end
        chk({name, "_latency"}, 64'(n - 1), 64'(W + 1));
        chk({name, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            v = sb.pop_front();
            chk({name, "_q"}, 64'(quo), 64'(v.q));
            chk({name, "_r"}, 64'(rem), 64'(v.r));
            chk({name, "_dbz"}, 64'(dbz), 64'(v.z));
            chk({name, "_ready_low"}, 64'(ready_o), 64'd0);
        end
        if (ready_i) begin
            @(posedge clk); #1;
            chk({name, "_after_consume"}, {62'd0, ready_o, valid_o}, 64'b10);
        end
    endtask

    initial begin
        logic [W-1:0] hq, hr;
        logic         hz;
        vec_t         v;

`ifdef DIV_SIGNED_EN
        tbl.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0});  // -100 / 7
        tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});  // -128 / -1
        tbl.push_back('{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0});  // 100 / -7
        tbl.push_back('{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0});  // -100 / -7
        tbl.push_back('{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1});  // -5 / 0
        tbl.push_back('{8'h32, 8'h06, 8'h08, 8'h02, 1'b0});
`else
        tbl.push_back('{8'd100, 8'd7,   8'd14,  8'd2, 1'b0});
        tbl.push_back('{8'd255, 8'd1,   8'd255, 8'd0, 1'b0});
        tbl.push_back('{8'd3,   8'd10,  8'd0,   8'd3, 1'b0});
        tbl.push_back('{8'd255, 8'd255, 8'd1,   8'd0, 1'b0});
        tbl.push_back('{8'd5,   8'd0,   8'hFF,  8'd5, 1'b1});
        tbl.push_back('{8'd200, 8'd13,  8'd15,  8'd5, 1'b0});
        tbl.push_back('{8'd1,   8'd255, 8'd0,   8'd1, 1'b0});
        tbl.push_back('{8'd0,   8'd5,   8'd0,   8'd0, 1'b0});
        tbl.push_back('{8'd128, 8'd2,   8'd64,  8'd0, 1'b0});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_outs", {47'd0, dbz, rem, quo}, 64'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 1'b1);
            collect($sformatf("vec%0d", i));
        end

        // Backpressure: hold result for 20 cycles while a new request waits.
        v = tbl[0];
        ready_i = 1'b0;
        issue(v.a, v.b, v.q, v.r, v.z, 1'b1);
        collect("stall");
        hq = quo; hr = rem; hz = dbz;
        dvd = 8'd9; dvs = 8'd3; valid_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("stall_c%0d", c), {45'd0, ready_o, valid_o, dbz, rem, quo},
                {45'd0, 1'b0, 1'b1, hz, hr, hq});
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", {62'd0, ready_o, valid_o}, 64'b10);
        repeat (12) @(posedge clk);
        #1;
        chk("stall_no_ghost", 64'(valid_o), 64'd0);

        // Reset in the middle of CALC discards the operation.
        issue(8'd77, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst", {62'd0, ready_o, valid_o}, 64'b10);
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_result", 64'(valid_o), 64'd0);
        issue(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b1);
        collect("post_rst");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_nonrestoring_divider.md
Name: seq_nonrestoring_divider

Overview:
- Iterative, parametrised unsigned non-restoring divider. Retires one quotient bit per clock, so one partial-remainder adder of width W+1 replaces the unrolled array.
- Sits between datapath producers and consumers behind valid/ready handshakes on both sides.
- Adds divide-by-zero flagging, backpressure on the result, and optional signed operation.

Parameters:
- W, 8, operand width. Dividend, divisor, quotient and remainder are all W bits. Legal range 2..64.
- CNT_W, $clog2(W+1), iteration counter width. Derived from W; not overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  operands valid.
- o_ready  out  1  divider can accept operands.
- i_dividend  in  W  dividend.
- i_divisor  in  W  divisor.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_quotient  out  W  quotient.
- o_remainder  out  W  remainder.
- o_dbz  out  1  divide-by-zero flag; qualified by o_valid.

Behaviour:
- Reset values: o_ready=1, o_valid=0, o_quotient=0, o_remainder=0, o_dbz=0, state=IDLE, counter=0.
- Reset at any time, including mid-CALC, mid-FIX or while DONE is stalled:
  - returns to IDLE on the next edge; the operation in flight is discarded and no result is produced.
- State machine:
  - IDLE: o_ready=1. On an edge with i_valid & o_ready:
    - latch dividend into the Q register and divisor into D;
    - clear the signed partial remainder P (W+1 bits);
    - counter=W; go to CALC.
    - If the divisor is 0, set the dbz flag internally; iterations still run, so latency is identical.
  - CALC: o_ready=0. Each cycle:
    - shift {P,Q} left by 1;
    - if old P≥0 then P=P−D, else P=P+D (D zero-extended to W+1);
    - new Q[0] = ~P[W];
    - decrement counter; go to FIX when the counter reaches 1→0.
  - FIX: one cycle.
    - If P<0, P=P+D. Remainder=P[W-1:0], quotient=Q.
    - If dbz: quotient=all ones, remainder=dividend.
    - Go to DONE.
  - DONE: o_valid=1 and outputs held stable. On an edge with i_ready, return to IDLE; o_valid drops.
- Latency:
  - Accept edge k → o_valid high after edge k+W+1, i.e. W cycles of CALC plus 1 of FIX.
  - Result consumed at edge m → o_ready high after edge m. No overlap between operations.
- Backpressure: while i_ready=0, DONE persists indefinitely with no change to any output.
- Inputs are sampled only at the accept edge; changes on i_dividend or i_divisor afterwards have no effect.
- i_valid during CALC, FIX or DONE is ignored (o_ready=0).
- Outputs o_quotient, o_remainder and o_dbz are registered. Between results they retain the last values; only o_valid qualifies them.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands and results are two's complement.
  - Magnitudes are taken at accept; the unsigned core runs unchanged.
  - FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative (truncating division).
  - Overflow case (most-negative ÷ −1): quotient = most-negative, remainder = 0, o_dbz = 0.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Latency is unchanged; negation happens inside FIX.
- Undefined: unsigned behaviour only; no negation logic is synthesised.

Test Plan:
- W=8, dividend 100, divisor 7, i_ready=1 → o_valid exactly 9 cycles after accept; q=14, r=2, dbz=0; o_ready=1 on the following cycle.
- 255/1, then 3/10, then 255/255, issued back-to-back → q=255 r=0; q=0 r=3; q=1 r=0. Each accepted only once o_ready=1.
- 5/0 → q=0xFF, r=5, dbz=1, same 9-cycle latency.
- 100/7 with i_ready held 0 for 20 cycles after o_valid → outputs stable and o_ready=0 throughout. A new i_valid is ignored until the result is consumed.
- Assert i_rst at CALC cycle 4 → next cycle o_ready=1, o_valid=0. A following 50/6 yields q=8 r=2.
- DIV_SIGNED_EN: −100/7 → q=0xF2, r=0xFE. −128/−1 → q=0x80, r=0. 100/−7 → q=0xF2, r=0x02.
